keypad_scan_decoder: RTL and testbench

//  Receive side of the 4x4 hex keypad interface.
//  - Drives one active-low column at a time on col; samples the active-low rows on fil.
//  - Debounces each press and decodes it to a 4-bit hex key code with a one-clock valid strobe.
//  - Sits between the keypad pins and the operand-entry/divider FSM; that FSM consumes the nibbles.

---
 rtl/keypad_scan_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_decoder.sv
// Scans a 4x4 active-low keypad, debounces presses and releases, and emits one hex code per press.
// Define KEYPAD_BYTE_ASM_EN to pair successive keys into a byte on byte_out/byte_valid.
module keypad_scan_decoder #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
`ifdef KEYPAD_BYTE_ASM_EN
  ,
  output logic [7:0] byte_out,
  output logic       byte_valid
`endif
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEB_TICKS + 1);
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEB_TICKS);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed} state_e;

  state_e          state_q, state_d;
  logic [3:0]      fil_meta_q, fil_sync_q;
  logic [DivW-1:0] div_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      col_q;
  logic [3:0]      pat_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            tick, single, accept, advance, latch;
  logic [3:0]      rows_low;
  logic [1:0]      row_idx, col_idx;
  logic [3:0]      key_new;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = 4'hE;
      4'hD:    k = 4'h0;
      4'hE:    k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick     = (div_q == DivMax);
  assign rows_low = ~fil_sync_q;
  // Exactly one row low: nonzero and a power of two.
  assign single   = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);

  always_comb begin
    row_idx = 2'd0;
    case (fil_sync_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign key_new = key_map(row_idx, col_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StScan;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (single) begin
            if (DEB_TICKS == 1) begin
              state_d = StPressed;
              cnt_d   = '0;
            end else begin
              state_d = StDebounce;
              cnt_d   = CntW'(1);
            end
          end
        end
        StDebounce: begin
          if (fil_sync_q == pat_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DebMax) begin
              state_d = StPressed;
              cnt_d   = '0;
            end
          end else begin
            state_d = StScan;
          end
        end
        StPressed: begin
          if (fil_sync_q == 4'hF) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DebMax) begin
              state_d = StScan;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Column advances on every tick that ends (or stays) in SCAN.
  always_comb begin
    accept   = (state_q != StPressed) && (state_d == StPressed);
    advance  = tick && (state_d == StScan);
    latch    = (state_q == StScan) && (state_d != StScan);
    key_held = (state_q == StPressed);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fil_meta_q  <= 4'hF;
      fil_sync_q  <= 4'hF;
      div_q       <= '0;
      cnt_q       <= '0;
      col_q       <= 4'b1110;
      pat_q       <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      fil_meta_q  <= fil;
      fil_sync_q  <= fil_meta_q;
      div_q       <= tick ? '0 : div_q + 1'b1;
      cnt_q       <= cnt_d;
      key_valid_q <= accept;
      if (advance) col_q <= {col_q[2:0], col_q[3]};
      if (latch) pat_q <= fil_sync_q;
      if (accept) key_code_q <= key_new;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

`ifdef KEYPAD_BYTE_ASM_EN
  logic       phase_q;
  logic [3:0] hi_q;
  logic [7:0] byte_q;
  logic       byte_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= 1'b0;
      hi_q         <= 4'h0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (accept) begin
        if (!phase_q) begin
          hi_q    <= key_new;
          phase_q <= 1'b1;
        end else begin
          byte_q       <= {hi_q, key_new};
          byte_valid_q <= 1'b1;
          phase_q      <= 1'b0;
        end
      end
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
`endif

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Scoreboard bench for keypad_scan_decoder: a keypad model drives rows from the scanned column,
// expected key events are queued at stimulus time and checked by a strobe monitor.
module tb_keypad_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fil;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
`ifdef KEYPAD_BYTE_ASM_EN
  logic [7:0] byte_out;
  logic       byte_valid;
`endif

  keypad_scan_decoder #(
    .SCAN_DIV (4),
    .DEB_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fil      (fil),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
`ifdef KEYPAD_BYTE_ASM_EN
    ,
    .byte_out  (byte_out),
    .byte_valid(byte_valid)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       bv;
    logic [7:0] byte_val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic       key_down  = 1'b0;
  logic [1:0] kr        = 2'd0;
  logic [1:0] kc        = 2'd0;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'hF;

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  always_comb begin
    if (force_en) fil = force_val;
    else if (key_down && (col[kc] == 1'b0)) fil = ~(4'b0001 << kr);
    else fil = 4'hF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: key_valid=1 code=%0h, expected no strobe", key_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, e.code});
`ifdef KEYPAD_BYTE_ASM_EN
        check("byte_valid", {31'd0, byte_valid}, {31'd0, e.bv});
        if (e.bv) check("byte_out", {24'd0, byte_out}, {24'd0, e.byte_val});
`endif
      end
    end
`ifdef KEYPAD_BYTE_ASM_EN
    if (rst === 1'b1 && byte_valid === 1'b1 && key_valid !== 1'b1) begin
      n_total++;
      $display("FAIL byte_valid_alone: byte_valid=1 key_valid=%b, expected coincident", key_valid);
    end
`endif
  end

  task automatic wait_col_change(output logic [3:0] nv, output int dt);
    logic [3:0] old;
    old = col;
    dt  = 0;
    while (col == old && dt < 64) begin
      @(negedge clk);
      dt++;
    end
    nv = col;
  endtask

  task automatic press_accept(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code,
                              input logic bv, input logic [7:0] bval);
    exp_t e;
    int   t;
    e.code = code;
    e.bv = bv;
    e.byte_val = bval;
    exp_q.push_back(e);
    kr = r;
    kc = c;
    key_down = 1'b1;
    t = 0;
    while (key_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("strobe_seen", {31'd0, key_valid}, 32'd1);
    check("held_at_strobe", {31'd0, key_held}, 32'd1);
    @(negedge clk);
    check("strobe_one_clk", {31'd0, key_valid}, 32'd0);
  endtask

  task automatic release_key();
    repeat (40) @(negedge clk);
    check("held_before_release", {31'd0, key_held}, 32'd1);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    check("held_after_release", {31'd0, key_held}, 32'd0);
  endtask

  logic [3:0] rot[4];
  logic [3:0] nv;
  logic [3:0] prev;
  int         dt;
  int         changes;

  initial begin
    rot[0] = 4'b1101;
    rot[1] = 4'b1011;
    rot[2] = 4'b0111;
    rot[3] = 4'b1110;

    // Reset and idle scanning
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_col", {28'd0, col}, 32'h0000000E);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_col_change(nv, dt);
      check("rotate_col", {28'd0, nv}, {28'd0, rot[i]});
      check("rotate_period", dt, 32'd4);
    end

    // Key '5' then a few more keys through the map
    press_accept(2'd1, 2'd1, 4'h5, 1'b0, 8'h00);
    release_key();
    wait_col_change(nv, dt);
    check("scan_resumed", {31'd0, (dt <= 4)}, 32'd1);
    press_accept(2'd0, 2'd0, 4'h1, 1'b1, 8'h51);
    release_key();
    press_accept(2'd0, 2'd3, 4'hA, 1'b0, 8'h00);
    release_key();
    press_accept(2'd2, 2'd2, 4'h9, 1'b1, 8'hA9);
    release_key();
    press_accept(2'd3, 2'd0, 4'hE, 1'b0, 8'h00);
    release_key();
    press_accept(2'd3, 2'd2, 4'hF, 1'b1, 8'hEF);
    release_key();

    // One-clock glitch on row 0 while column 0 is driven
    dt = 0;
    while (col != 4'b1110 && dt < 64) begin
      @(negedge clk);
      dt++;
    end
    force_val = 4'b1110;
    force_en  = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    repeat (30) @(negedge clk);
    wait_col_change(nv, dt);
    check("scan_after_glitch", {31'd0, (dt <= 4)}, 32'd1);

    // Two rows low: never a key, scanning continues every tick
    force_val = 4'b1100;
    force_en  = 1'b1;
    changes = 0;
    prev = col;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col != prev) changes++;
      prev = col;
    end
    force_en = 1'b0;
    check("multi_row_rotations", changes, 32'd10);
    repeat (10) @(negedge clk);

    // Reset clears the nibble phase; '4' then '5' forms 0x45
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    press_accept(2'd1, 2'd0, 4'h4, 1'b0, 8'h00);
    release_key();
    press_accept(2'd1, 2'd1, 4'h5, 1'b1, 8'h45);
    release_key();

    // Asynchronous reset while 'D' is held; it re-debounces once after reset
    press_accept(2'd3, 2'd3, 4'hD, 1'b0, 8'h00);
    repeat (10) @(negedge clk);
    #5 rst = 1'b0;
    #1;
    check("midrst_col", {28'd0, col}, 32'h0000000E);
    check("midrst_key_code", {28'd0, key_code}, 32'd0);
    check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_key_held", {31'd0, key_held}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    press_accept(2'd3, 2'd3, 4'hD, 1'b0, 8'h00);
    release_key();
    repeat (40) @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
